// File: rtl/bcd_subtractor_seq.sv
// bcd_subtractor_seq: sequential packed-BCD subtractor a - b - bin, one digit per clock, LSD first.
// Ports: clk, rst_n (async active-low), start/ready handshake, busy while digits are processed,
// done one-cycle result pulse, diff/bout/err/neg held until the next accepted start.
// Build option: define BCD_SUB_SIGNED_MAG_EN to convert negative results to magnitude with neg=1.
module bcd_subtractor_seq #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                bin,
  output logic                ready,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] diff,
  output logic                bout,
  output logic                err,
  output logic                neg
);
  localparam int KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
`ifdef BCD_SUB_SIGNED_MAG_EN
  typedef enum logic [1:0] {IDLE, SUB, NEGC, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;
`endif
  state_t state_q, state_d;
  logic [4*DIGITS-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic [KW-1:0] k_q, k_d;
  logic brw_q, brw_d, bout_q, bout_d, err_q, err_d, neg_q, neg_d;
  logic bad, last;
  logic [3:0] x, y, dig;
  logic [4:0] t;
  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      bad = bad | (a[i*4 +: 4] > 4'd9) | (b[i*4 +: 4] > 4'd9);
  end
  // NEGC reuses the digit rule as 0 - diff_k - borrow, rewriting diff in place.
`ifdef BCD_SUB_SIGNED_MAG_EN
  assign x = (state_q == NEGC) ? 4'd0 : a_q[{k_q, 2'b00} +: 4];
  assign y = (state_q == NEGC) ? diff_q[{k_q, 2'b00} +: 4] : b_q[{k_q, 2'b00} +: 4];
`else
  assign x = a_q[{k_q, 2'b00} +: 4];
  assign y = b_q[{k_q, 2'b00} +: 4];
`endif
  assign t = {1'b0, x} - {1'b0, y} - {4'b0, brw_q};
  assign dig = t[4] ? t[3:0] + 4'd10 : t[3:0];
  assign last = (k_q == KW'(DIGITS - 1));
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    k_d = k_q;
    brw_d = brw_q;
    diff_d = diff_q;
    bout_d = bout_q;
    err_d = err_q;
    neg_d = neg_q;
    if (state_q == IDLE || state_q == DONE) begin
      state_d = IDLE;
      if (start) begin
        a_d = a;
        b_d = b;
        brw_d = bin;
        k_d = '0;
        neg_d = 1'b0;
        err_d = bad;
        state_d = bad ? DONE : SUB;
        if (bad) begin
          diff_d = '0;
          bout_d = 1'b0;
        end
      end
    end else begin
      diff_d[{k_q, 2'b00} +: 4] = dig;
      brw_d = t[4];
      k_d = k_q + KW'(1);
      if (last) begin
        state_d = DONE;
        if (state_q == SUB) bout_d = t[4];
`ifdef BCD_SUB_SIGNED_MAG_EN
        if (state_q == SUB && t[4]) begin
          state_d = NEGC;
          k_d = '0;
          brw_d = 1'b0;
        end
        if (state_q == NEGC) neg_d = 1'b1;
`endif
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      k_q <= '0;
      brw_q <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
      err_q <= 1'b0;
      neg_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      k_q <= k_d;
      brw_q <= brw_d;
      diff_q <= diff_d;
      bout_q <= bout_d;
      err_q <= err_d;
      neg_q <= neg_d;
    end
  end
  assign ready = (state_q == IDLE) || (state_q == DONE);
  assign busy = !ready;
  assign done = (state_q == DONE);
  assign diff = diff_q;
  assign bout = bout_q;
  assign err = err_q;
  assign neg = neg_q;
endmodule

// File: tb/tb_bcd_subtractor_seq.sv
// tb_bcd_subtractor_seq: table-driven scoreboard bench for bcd_subtractor_seq (DIGITS=4).
module tb_bcd_subtractor_seq;
`ifdef BCD_SUB_SIGNED_MAG_EN
  localparam bit SM = 1'b1;
`else
  localparam bit SM = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, bin = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic ready, busy, done, bout, err, neg;
  logic [15:0] diff;
  typedef struct {logic [15:0] diff; logic bout, err, neg; int lat;} exp_t;
  typedef struct {logic [15:0] a, b; logic bin; logic [15:0] diff; logic bout, err, neg; int lat;} vec_t;
  exp_t sbq[$];
  vec_t tv[12];
  int checks = 0, failures = 0;
  bcd_subtractor_seq #(.DIGITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .ready(ready), .busy(busy), .done(done), .diff(diff), .bout(bout), .err(err), .neg(neg)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask
  task automatic push(input logic [15:0] d, input logic bo, input logic e, input logic n, input int l);
    exp_t x;
    x.diff = d;
    x.bout = bo;
    x.err = e;
    x.neg = n;
    x.lat = l;
    sbq.push_back(x);
  endtask
  // Called #1 after the start-sampling edge; latency = edges after that one until done is seen.
  task automatic wait_done();
    int n = 0;
    exp_t e;
    while (!done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    e = sbq.pop_front();
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL done_timeout act=%0d exp=%0d", n, e.lat);
      return;
    end
    chk("latency", n, e.lat);
    chk("diff", diff, e.diff);
    chk("bout", bout, e.bout);
    chk("err", err, e.err);
    chk("neg", neg, e.neg);
    chk("ready_at_done", ready, 1'b1);
    chk("busy_at_done", busy, 1'b0);
  endtask
  task automatic run(input vec_t v);
    @(negedge clk);
    a = v.a;
    b = v.b;
    bin = v.bin;
    start = 1'b1;
    push(v.diff, v.bout, v.err, v.neg, v.lat);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done();
  endtask
  task automatic chk_reset_outputs();
    chk("rst_ready", ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_diff", diff, 16'h0000);
    chk("rst_bout", bout, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_neg", neg, 1'b0);
  endtask
  initial begin
    tv[0] = '{16'h4321, 16'h1234, 1'b0, 16'h3087, 1'b0, 1'b0, 1'b0, 4};
    if (SM) tv[1] = '{16'h0000, 16'h0001, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b1, 8};
    else    tv[1] = '{16'h0000, 16'h0001, 1'b0, 16'h9999, 1'b1, 1'b0, 1'b0, 4};
    tv[2] = '{16'h5000, 16'h4999, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 4};
    tv[3] = '{16'h12A4, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 0};
    tv[4] = '{16'h1000, 16'h0001, 1'b0, 16'h0999, 1'b0, 1'b0, 1'b0, 4};
    if (SM) tv[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b1, 8};
    else    tv[5] = '{16'h0000, 16'h0000, 1'b1, 16'h9999, 1'b1, 1'b0, 1'b0, 4};
    tv[6] = '{16'h9999, 16'h0000, 1'b0, 16'h9999, 1'b0, 1'b0, 1'b0, 4};
    tv[7] = '{16'h0001, 16'h12F0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 0};
    if (SM) tv[8] = '{16'h9999, 16'h9999, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b1, 8};
    else    tv[8] = '{16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0, 1'b0, 4};
    if (SM) tv[9] = '{16'h2500, 16'h7500, 1'b0, 16'h5000, 1'b1, 1'b0, 1'b1, 8};
    else    tv[9] = '{16'h2500, 16'h7500, 1'b0, 16'h5000, 1'b1, 1'b0, 1'b0, 4};
    tv[10] = '{16'h0123, 16'h0123, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 4};
    tv[11] = '{16'h8765, 16'h4321, 1'b1, 16'h4443, 1'b0, 1'b0, 1'b0, 4};
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) run(tv[i]);
    // start held high through SUB: new operands ignored until DONE, where they are accepted.
    @(negedge clk);
    a = 16'h4321;
    b = 16'h1234;
    bin = 1'b0;
    start = 1'b1;
    push(16'h3087, 1'b0, 1'b0, 1'b0, 4);
    @(posedge clk);
    #1;
    a = 16'h9999;
    b = 16'h9999;
    chk("held_busy", busy, 1'b1);
    chk("held_ready", ready, 1'b0);
    wait_done();
    push(16'h0000, 1'b0, 1'b0, 1'b0, 4);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("rearm_busy", busy, 1'b1);
    chk("rearm_done", done, 1'b0);
    wait_done();
    // Reset asserted while digit 1 of 4321-1234 is in flight.
    @(negedge clk);
    a = 16'h4321;
    b = 16'h1234;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    run(tv[4]);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bcd_subtractor_seq.md
Name: bcd_subtractor_seq

Overview:
- Sequential multi-digit BCD subtractor: computes a − b − bin, one BCD digit per clock, least-significant digit first.
- Companion to the combinational 4-digit BCD adder chain; provides the borrow/subtract direction of the same packed-BCD datapath.
- Uses a start/ready/done handshake so it can sit behind a controller or a register-mapped wrapper.

Parameters:
- DIGITS, 4, number of packed BCD digits per operand (≥1).

Ports:
- clk   input  1  rising-edge clock.
- rst_n   input  1  reset, asynchronous, active-low.
- start   input  1  request; sampled only while ready=1.
- a   input  4*DIGITS  minuend, packed BCD, digit 0 in [3:0].
- b   input  4*DIGITS  subtrahend, packed BCD.
- bin   input  1  borrow-in, applied at digit 0.
- ready   output  1  high when the FSM is in IDLE or DONE and can accept start.
- busy   output  1  high while digits are being processed.
- done   output  1  one-cycle pulse; result valid.
- diff   output  4*DIGITS  packed BCD result, held until the next accepted start.
- bout   output  1  final borrow-out, held with diff.
- err   output  1  invalid input digit (>9) in a or b, held with diff.
- neg   output  1  result-is-negative flag (see Optional Feature).

Behaviour:
- Reset (rst_n low, any time, including mid-operation): FSM goes to IDLE; diff=0, bout=0, err=0, neg=0, done=0, busy=0, ready=1. Internal operand and borrow registers are cleared.
- FSM states: IDLE, SUB, (NEGC), DONE.
- IDLE: ready=1. On start=1, latch a, b and bin, and clear digit index k=0.
  - If any digit of a or b is >9: go to DONE with diff=0, bout=0, neg=0, err=1. Latency is 1 edge.
  - Otherwise: go to SUB with err=0 and borrow=bin.
- SUB: busy=1, ready=0. Each edge processes digit k:
  - t = a_k − b_k − borrow, computed 5-bit signed.
  - If t<0: diff_k = t+10 and borrow=1; else diff_k = t and borrow=0.
  - k increments. After digit DIGITS−1: bout=borrow, and the FSM goes to DONE (or to NEGC, see Optional Feature).
- DONE: done=1 for exactly one cycle; ready=1, busy=0.
  - start=1 in DONE is accepted exactly as in IDLE.
  - If start=0, go to IDLE.
- Latency, valid operands, feature off: start sampled at edge E0; done is high in the cycle following edge E(DIGITS). That is 4 cycles for DIGITS=4.
- start while busy=1 is ignored; the operand inputs are don't-care then.
- diff digits not yet rewritten during SUB hold their previous-operation values. Only the done cycle defines validity.
- No arithmetic wraps beyond the borrow chain. With the feature off, a negative result appears as the ten's complement with bout=1.

Optional Feature:
- Macro: BCD_SUB_SIGNED_MAG_EN.
- Defined: if the final borrow is 1, the FSM enters NEGC instead of DONE.
  - NEGC runs DIGITS further cycles computing 0 − diff_k − borrow, using the same digit rule with initial borrow 0, in place.
  - Result: diff holds the magnitude, neg=1, bout=1. Then the FSM goes to DONE.
  - Total latency for a negative result is 2*DIGITS edges; non-negative results are unchanged, with neg=0.
- Undefined: NEGC state is not built; neg is tied to 0; diff is the raw ten's complement.

Test Plan:
- a=0x4321, b=0x1234, bin=0, start pulse -> done at 4th cycle after start edge, diff=0x3087, bout=0, err=0.
- a=0x0000, b=0x0001 -> without macro: diff=0x9999, bout=1, neg=0, latency 4. With BCD_SUB_SIGNED_MAG_EN: diff=0x0001, neg=1, bout=1, latency 8.
- a=0x5000, b=0x4999, bin=1 -> diff=0x0000, bout=0; borrow ripples through all digits.
- a=0x12A4, b=0x0001 -> done one edge after start, err=1, diff=0x0000, bout=0; the next valid op clears err.
- start held high through SUB -> second request ignored until DONE. start=1 in the DONE cycle (a=0x9999, b=0x9999) -> accepted, next result 0x0000.
- rst_n low for 1 cycle during the 2nd digit of a=0x4321−0x1234 -> all outputs 0, ready=1 immediately. A subsequent op (0x1000−0x0001) gives 0x0999.
